// File: rtl/regfile_pkg.sv
// Shared defaults, constants and bus-unpacking helper for the multi-port integer register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int BUS_MAX    = 512;

  localparam logic [BUS_MAX-1:0] ZERO_WORD = '0;
  localparam logic EN_ON  = 1'b1;
  localparam logic EN_OFF = 1'b0;

  // Extract field idx of width w from a packed bus (zero-extended into BUS_MAX bits).
  function automatic logic [BUS_MAX-1:0] unpack_field(input logic [BUS_MAX-1:0] bus,
                                                      input int unsigned idx,
                                                      input int unsigned w);
    logic [BUS_MAX-1:0] mask;
    mask = (BUS_MAX'(1) << w) - BUS_MAX'(1);
    return (bus >> (idx * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits (set at issue, cleared at write-back, flushed in bulk) and their count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        waddr0,
  input  logic                     wclr0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        waddr1,
  input  logic                     wclr1,
  output logic [(1<<ADDR_W)-1:0]   pend,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] pend_nxt;
  logic [ADDR_W:0]     cnt_nxt;

  // Register 0 is skipped so it can never become pending or be counted.
  always_comb begin
    pend_nxt = '0;
    cnt_nxt  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (flush == EN_ON)
        pend_nxt[r] = 1'b0;
      else if (iss_en == EN_ON && iss_addr == ADDR_W'(r))
        pend_nxt[r] = 1'b1;
      else if ((we0 == EN_ON && wclr0 == EN_ON && waddr0 == ADDR_W'(r)) ||
               (we1 == EN_ON && wclr1 == EN_ON && waddr1 == ADDR_W'(r)))
        pend_nxt[r] = 1'b0;
      else
        pend_nxt[r] = pend[r];
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Integer register file: two write-back ports, RD_PORTS bypassed read ports, pending scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we0,
  input  logic [ADDR_W-1:0]            waddr0,
  input  logic [DATA_W-1:0]            wdata0,
  input  logic                         wclr0,
  input  logic                         we1,
  input  logic [ADDR_W-1:0]            waddr1,
  input  logic [DATA_W-1:0]            wdata1,
  input  logic                         wclr1,
  input  logic [RD_PORTS-1:0]          re,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata,
  output logic [RD_PORTS-1:0]          rbusy,
  input  logic                         iss_en,
  input  logic [ADDR_W-1:0]            iss_addr,
  input  logic                         flush,
  output logic [ADDR_W:0]              pend_cnt
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pend;

  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .we0      (we0),
    .waddr0   (waddr0),
    .wclr0    (wclr0),
    .we1      (we1),
    .waddr1   (waddr1),
    .wclr1    (wclr1),
    .pend     (pend),
    .pend_cnt (pend_cnt)
  );

  // Port 1 is written last so it wins a same-address conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= DATA_W'(ZERO_WORD);
    end else begin
      if (we0 == EN_ON && waddr0 != '0) regs[waddr0] <= wdata0;
      if (we1 == EN_ON && waddr1 != '0) regs[waddr1] <= wdata1;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              bsy;
    logic              clr0;
    logic              clr1;

    assign ra   = ADDR_W'(unpack_field(BUS_MAX'(raddr), i, ADDR_W));
    assign clr0 = we0 & wclr0 & (waddr0 == ra);
    assign clr1 = we1 & wclr1 & (waddr1 == ra);

    // Bypass order mirrors write priority: port 1 data beats port 0 beats storage.
    always_comb begin
      rd  = DATA_W'(ZERO_WORD);
      bsy = EN_OFF;
      if (!rst && re[i] == EN_ON && ra != '0) begin
        if (we1 == EN_ON && waddr1 == ra)
          rd = wdata1;
        else if (we0 == EN_ON && waddr0 == ra)
          rd = wdata0;
        else
          rd = regs[ra];
        bsy = pend[ra] & ~clr0 & ~clr1;
      end
    end

    assign rdata[i*DATA_W +: DATA_W] = rd;
    assign rbusy[i]                  = bsy;
  end

endmodule
